// File: rtl/divider_iter_core_if.sv
// rtl/divider_iter_core_if.sv - start/operand/result bundle for divider_iter_core
//   i_call                : start request, level; its rising edge starts a division
//   num_data / dem_data   : dividend / divisor, sampled on the start edge
//   o_x / o_y             : quotient / remainder, held until the next completion
//   o_valid               : one-cycle pulse when o_x/o_y update
//   o_busy                : high while a division is in flight
//   o_div_zero            : last completed division had a zero divisor
//   master = requester side, slave = divider core side
interface divider_iter_core_if;
    logic        i_call;
    logic [31:0] num_data;
    logic [31:0] dem_data;
    logic [31:0] o_x;
    logic [31:0] o_y;
    logic        o_valid;
    logic        o_busy;
    logic        o_div_zero;

    modport master (
        output i_call, num_data, dem_data,
        input  o_x, o_y, o_valid, o_busy, o_div_zero
    );

    modport slave (
        input  i_call, num_data, dem_data,
        output o_x, o_y, o_valid, o_busy, o_div_zero
    );
endinterface

// File: rtl/divider_iter_core.sv
// rtl/divider_iter_core.sv - iterative 32-bit restoring divider, BITS_PER_CYCLE quotient bits per clock
//   divider_clk : core clock
//   reset_n     : asynchronous active-low reset
//   bus         : divider_iter_core_if.slave (i_call, num_data, dem_data, o_x, o_y, o_valid, o_busy, o_div_zero)
//   SIGNED      : 0 unsigned, 1 two's-complement with quotient truncated toward zero
//   BITS_PER_CYCLE : 1, 2, 4 or 8
//   DIVIDER_EARLY_OUT_EN : when defined, |num| < |den| (den != 0) skips the iteration phase
module divider_iter_core #(
    parameter bit SIGNED         = 1'b0,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic               divider_clk,
    input  logic               reset_n,
    divider_iter_core_if.slave bus
);
    localparam int N     = 32 / BITS_PER_CYCLE;
    localparam int CNT_W = 5;

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
              BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
            $error("divider_iter_core: BITS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               i_call_d;
    logic               start;
    logic               early;
    logic               last_iter;
    logic [31:0]        rem_q;
    logic [31:0]        quo_q;
    logic [31:0]        dvs_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sign_q;
    logic               sign_r;
    logic               dz_q;
    logic [31:0]        mag_num;
    logic [31:0]        mag_den;
    logic [31:0]        rem_nxt;
    logic [31:0]        quo_nxt;

    function automatic logic [31:0] mag(input logic [31:0] v);
        return (SIGNED && v[31]) ? (~v + 32'd1) : v;
    endfunction

    assign mag_num   = mag(bus.num_data);
    assign mag_den   = mag(bus.dem_data);
    assign start     = (state == S_IDLE) && bus.i_call && !i_call_d;
    assign last_iter = (cnt_q == CNT_W'(N - 1));

`ifdef DIVIDER_EARLY_OUT_EN
    assign early = (bus.dem_data != 32'd0) && (mag_num < mag_den);
`else
    assign early = 1'b0;
`endif

    // Chained restoring steps. The dividend register doubles as the quotient
    // register: dividend bits shift out of the top while quotient bits enter at
    // the bottom.
    always_comb begin
        logic [31:0] r;
        logic [31:0] q;
        logic [32:0] r33;
        r   = rem_q;
        q   = quo_q;
        r33 = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            r33 = {r, q[31]};
            q   = {q[30:0], 1'b0};
            if (r33 >= {1'b0, dvs_q}) begin
                r33  = r33 - {1'b0, dvs_q};
                q[0] = 1'b1;
            end
            r = r33[31:0];
        end
        rem_nxt = r;
        quo_nxt = q;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = early ? S_DONE : S_RUN;
            S_RUN:  if (last_iter) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge divider_clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge divider_clk or negedge reset_n) begin
        if (!reset_n) begin
            i_call_d       <= 1'b0;
            rem_q          <= '0;
            quo_q          <= '0;
            dvs_q          <= '0;
            cnt_q          <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            dz_q           <= 1'b0;
            bus.o_x        <= '0;
            bus.o_y        <= '0;
            bus.o_valid    <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_div_zero <= 1'b0;
        end else begin
            i_call_d    <= bus.i_call;
            bus.o_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvs_q      <= mag_den;
                        cnt_q      <= '0;
                        sign_q     <= SIGNED & (bus.num_data[31] ^ bus.dem_data[31]);
                        sign_r     <= SIGNED & bus.num_data[31];
                        dz_q       <= (bus.dem_data == 32'd0);
                        bus.o_busy <= 1'b1;
                        // Early-out parks |num| in the remainder with a zero
                        // quotient, so the normal sign fix-up restores num.
                        if (early) begin
                            quo_q <= '0;
                            rem_q <= mag_num;
                        end else begin
                            quo_q <= mag_num;
                            rem_q <= '0;
                        end
                    end
                end
                S_RUN: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_DONE: begin
                    // A zero divisor leaves rem = |num|, so the sign fix-up
                    // yields num itself; only the quotient is forced.
                    bus.o_x        <= dz_q ? 32'hFFFF_FFFF : (sign_q ? (~quo_q + 32'd1) : quo_q);
                    bus.o_y        <= sign_r ? (~rem_q + 32'd1) : rem_q;
                    bus.o_div_zero <= dz_q;
                    bus.o_valid    <= 1'b1;
                    bus.o_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
